// File: rtl/cache_pkg.sv
// Shared widths, state encoding and helper for the write-back cache controller.
package cache_pkg;

    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    localparam int DEF_ADDR_WIDTH   = 28;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_BLOCK_SIZE   = 256;
    localparam int DEF_CACHE_SIZE   = 65536;
    localparam int DEF_OFFSET_WIDTH = log2(DEF_BLOCK_SIZE / DEF_DATA_WIDTH);
    localparam int DEF_INDEX_WIDTH  = log2(DEF_CACHE_SIZE * 8 / DEF_BLOCK_SIZE);
    localparam int DEF_TAG_WIDTH    = DEF_ADDR_WIDTH - DEF_INDEX_WIDTH - DEF_OFFSET_WIDTH;
    localparam int DEF_BADDR_WIDTH  = DEF_ADDR_WIDTH - DEF_OFFSET_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COMPARE   = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_ALLOCATE  = 3'd3,
        ST_REFILL    = 3'd4
    } state_t;

endpackage

// File: rtl/cache_word_merge.sv
// Word select (reads) and single-word replace (writes) within one cache line.
module cache_word_merge #(
    parameter int DATA_WIDTH   = 32,
    parameter int BLOCK_SIZE   = 256,
    parameter int OFFSET_WIDTH = 3
) (
    input  logic [BLOCK_SIZE-1:0]   line,
    input  logic [OFFSET_WIDTH-1:0] offset,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   word,
    output logic [BLOCK_SIZE-1:0]   merged
);
    localparam int WORDS = BLOCK_SIZE / DATA_WIDTH;

    logic [DATA_WIDTH-1:0] words [WORDS];

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign words[gi] = line[gi*DATA_WIDTH +: DATA_WIDTH];
            assign merged[gi*DATA_WIDTH +: DATA_WIDTH] =
                (offset == OFFSET_WIDTH'(gi)) ? wdata : line[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign word = words[offset];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped write-back cache controller: hit service, dirty writeback, refill.
module cache_controller
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 256,
    parameter int CACHE_SIZE = 65536
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_rd,
    input  logic                    cpu_wr,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    output logic                    cpu_ready,
    output logic [ADDR_WIDTH-1:0]   cache_addr,
    output logic [BLOCK_SIZE-1:0]   cache_data_write,
    output logic                    cache_dirty_write,
    output logic                    cache_write_en,
    input  logic [BLOCK_SIZE-1:0]   cache_data_read,
    input  logic                    cache_dirty_read,
    input  logic                    cache_hit,
    input  logic [14:0]             cache_replace_tag,
    output logic                    mem_rd,
    output logic                    mem_wr,
    output logic [ADDR_WIDTH-log2(BLOCK_SIZE/DATA_WIDTH)-1:0] mem_addr,
    output logic [BLOCK_SIZE-1:0]   mem_wdata,
    input  logic [BLOCK_SIZE-1:0]   mem_rdata,
    input  logic                    mem_ready,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
);
    localparam int OFFSET_WIDTH = log2(BLOCK_SIZE / DATA_WIDTH);
    localparam int INDEX_WIDTH  = log2(CACHE_SIZE * 8 / BLOCK_SIZE);
    localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic                    wr_reg;
    logic                    refilled_reg;

    logic [OFFSET_WIDTH-1:0] offset;
    logic [INDEX_WIDTH-1:0]  index;
    logic [DATA_WIDTH-1:0]   sel_word;
    logic [BLOCK_SIZE-1:0]   merged_line;
    logic                    unused_tag_bits;

    assign offset          = addr_reg[OFFSET_WIDTH-1:0];
    assign index           = addr_reg[OFFSET_WIDTH +: INDEX_WIDTH];
    assign cache_addr      = addr_reg;
    assign unused_tag_bits = ^cache_replace_tag[14:TAG_WIDTH];

    cache_word_merge #(
        .DATA_WIDTH  (DATA_WIDTH),
        .BLOCK_SIZE  (BLOCK_SIZE),
        .OFFSET_WIDTH(OFFSET_WIDTH)
    ) u_merge (
        .line  (cache_data_read),
        .offset(offset),
        .wdata (wdata_reg),
        .word  (sel_word),
        .merged(merged_line)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            addr_reg          <= '0;
            wdata_reg         <= '0;
            wr_reg            <= 1'b0;
            refilled_reg      <= 1'b0;
            cpu_rdata         <= '0;
            cpu_ready         <= 1'b0;
            cache_data_write  <= '0;
            cache_dirty_write <= 1'b0;
            cache_write_en    <= 1'b0;
            mem_rd            <= 1'b0;
            mem_wr            <= 1'b0;
            mem_addr          <= '0;
            mem_wdata         <= '0;
            hit_count         <= '0;
            miss_count        <= '0;
        end else begin
            cpu_ready      <= 1'b0;
            cache_write_en <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cpu_rd || cpu_wr) begin
                        addr_reg     <= cpu_addr;
                        wdata_reg    <= cpu_wdata;
                        wr_reg       <= cpu_wr;
                        refilled_reg <= 1'b0;
                        state_reg    <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (cache_hit) begin
                        cpu_ready <= 1'b1;
                        if (wr_reg) begin
                            cache_write_en    <= 1'b1;
                            cache_data_write  <= merged_line;
                            cache_dirty_write <= 1'b1;
                        end else begin
                            cpu_rdata <= sel_word;
                        end
                        // The compare that follows a refill finishes a miss, not a hit.
                        if (!refilled_reg && hit_count != '1) begin
                            hit_count <= hit_count + 32'd1;
                        end
                        state_reg <= ST_IDLE;
                    end else begin
                        if (!refilled_reg && miss_count != '1) begin
                            miss_count <= miss_count + 32'd1;
                        end
                        if (cache_dirty_read) begin
                            mem_wr    <= 1'b1;
                            mem_addr  <= {cache_replace_tag[TAG_WIDTH-1:0], index};
                            mem_wdata <= cache_data_read;
                            state_reg <= ST_WRITEBACK;
                        end else begin
                            mem_rd    <= 1'b1;
                            mem_addr  <= addr_reg[ADDR_WIDTH-1:OFFSET_WIDTH];
                            state_reg <= ST_ALLOCATE;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ready) begin
                        mem_wr    <= 1'b0;
                        mem_rd    <= 1'b1;
                        mem_addr  <= addr_reg[ADDR_WIDTH-1:OFFSET_WIDTH];
                        state_reg <= ST_ALLOCATE;
                    end
                end
                ST_ALLOCATE: begin
                    // cache_data_write doubles as the fill register for the refill write.
                    if (mem_ready) begin
                        mem_rd            <= 1'b0;
                        cache_data_write  <= mem_rdata;
                        cache_dirty_write <= 1'b0;
                        cache_write_en    <= 1'b1;
                        state_reg         <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    refilled_reg <= 1'b1;
                    state_reg    <= ST_COMPARE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
